// File: rtl/avm_read_master.sv
// Avalon-MM burst-less read master: fetches word_count words starting at
// base_addr and streams them out through a small credit-managed FIFO.
module avm_read_master #(
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REM_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Next-state, FIFO bookkeeping and look-ahead read credit
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        accept     = rd_q & ~avm_waitrequest;
        push       = inflight_q;
        pop        = (count_q != '0) & out_ready;
        inflight_d = accept;

        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        state_d     = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_d && (count_d == '0)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read is registered, so credit is judged on next-cycle occupancy;
        // a stalled read is held until the slave takes it.
        rd_d = (rd_q & avm_waitrequest) |
               ((state_d == S_ISSUE) && (remaining_d != '0) &&
                ((CNT_W'(accept) + count_d) < CNT_W'(FIFO_DEPTH)));

        busy_d = (state_d != S_IDLE);
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; read data is captured the cycle after its read was accepted
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= avm_readdata;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_chipselect = rd_q;
    assign avm_write      = 1'b0;
    assign avm_byteenable = '1;
    assign out_data       = mem_q[rptr_q];
    assign out_valid      = (count_q != '0);

endmodule

// File: tb/tb_avm_read_master.sv
// Bench for avm_read_master: on-chip RAM slave, per-job scoreboard, table and random jobs.
module tb_avm_read_master;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    avm_read_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [RAM_WORDS];

    // Slave: data appears exactly one cycle after an accepted read, junk otherwise
    always @(posedge clk) begin
        avm_readdata <= (avm_read && !avm_waitrequest) ? ram[avm_address] : $urandom();
    end

    int total = 0;
    int bad   = 0;

    // Scoreboard state, owned by the monitor
    logic [DATA_W-1:0] exp_data [$];
    logic [ADDR_W-1:0] exp_addr [$];
    int acc, pops, done_cnt, cyc, start_cyc, last_pop_cyc, job_n;
    bit mon_en, in_job, hold_pend;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] last_word;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Protocol and data monitor, sampled on the falling edge
    task automatic monitor();
        int occ;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                hold_pend = 1'b0;
                in_job    = 1'b0;
                continue;
            end
            if (hold_pend) begin
                chk("addr_hold_read", avm_read, 1);
                chk("addr_hold_addr", avm_address, hold_addr);
            end
            if (avm_read && !avm_waitrequest) begin
                occ = acc - pops;
                chk("read_credit", occ < FIFO_DEPTH, 1);
                chk("cs_with_read", avm_chipselect, 1);
                chk("read_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) chk("read_addr", avm_address, exp_addr.pop_front());
                acc++;
            end
            if (out_valid && out_ready) begin
                chk("word_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) chk("out_data", out_data, exp_data.pop_front());
                last_word    = out_data;
                pops++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
                if (job_n == 0) chk("done_lat_zero", cyc - start_cyc, 1);
                else            chk("done_after_pop", cyc - last_pop_cyc, 1);
                in_job = 1'b0;
            end else if (in_job) begin
                chk("busy_in_job", busy, 1);
            end
            hold_pend = avm_read && avm_waitrequest;
            hold_addr = avm_address;
            // New job accepted: expected stream is RAM[(base+i) mod 4], i < count
            if (start && !busy) begin
                exp_data.delete();
                exp_addr.delete();
                job_n = int'(word_count);
                for (int i = 0; i < job_n; i++) begin
                    exp_addr.push_back(ADDR_W'(int'(base_addr) + i));
                    exp_data.push_back(ram[(int'(base_addr) + i) % RAM_WORDS]);
                end
                acc = 0; pops = 0; done_cnt = 0;
                start_cyc = cyc; last_pop_cyc = -100;
                in_job = (job_n != 0);
            end
        end
    endtask

    task automatic run_job(input logic [1:0] b, input logic [2:0] n, input int rm, input int wm,
                           input bit spur, input int exp_reads, input logic [DATA_W-1:0] exp_last);
        int stall_left;
        bit got;
        stall_left = 3;
        got = 1'b0;
        @(posedge clk); #1;
        out_ready = (rm != 2);
        avm_waitrequest = 1'b0;
        start = 1'b1; base_addr = b; word_count = n;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != 0) begin got = 1'b1; break; end
            if (rm == 2 && c == 12) begin
                chk("bp_reads_capped", acc, FIFO_DEPTH);
                chk("bp_read_low", avm_read, 0);
            end
            case (rm)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (c >= 12);
            endcase
            case (wm)
                0:       avm_waitrequest = 1'b0;
                1:       avm_waitrequest = ($urandom_range(0, 2) == 0);
                default: begin
                    avm_waitrequest = (acc == 1) && avm_read && (stall_left > 0);
                    if (avm_waitrequest) stall_left--;
                end
            endcase
            if (spur && c == 2 && busy) begin
                start = 1'b1; base_addr = ~b; word_count = 3'd5;
            end
        end
        chk("job_done_seen", got, 1);
        out_ready = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("done_once", done_cnt, 1);
        chk("reads_issued", acc, exp_reads);
        chk("stream_drained", exp_data.size(), 0);
        chk("idle_after_job", busy, 0);
        if (n != 0) chk("last_word", last_word, exp_last);
    endtask

    typedef struct {
        logic [1:0]        base;
        logic [2:0]        cnt;
        int                rm;
        int                wm;
        bit                spur;
        int                exp_reads;
        logic [DATA_W-1:0] exp_last;
    } vec_t;

    vec_t tbl [7];

    task automatic load_default_ram();
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
    endtask

    initial begin
        logic [1:0]        rb;
        logic [2:0]        rn;
        logic [DATA_W-1:0] rl;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        out_ready = 1'b0; avm_waitrequest = 1'b0; mon_en = 1'b0;
        cyc = 0; acc = 0; pops = 0; done_cnt = 0; job_n = 0;
        start_cyc = 0; last_pop_cyc = -100; in_job = 1'b0; hold_pend = 1'b0;
        hold_addr = '0; last_word = '0;
        load_default_ram();

        // base, count, ready mode, wait mode, spurious start, reads, last word
        tbl[0] = '{2'd0, 3'd4, 0, 0, 1'b0, 4, 32'h44};
        tbl[1] = '{2'd3, 3'd3, 0, 0, 1'b0, 3, 32'h22};
        tbl[2] = '{2'd0, 3'd0, 0, 0, 1'b0, 0, 32'h0};
        tbl[3] = '{2'd1, 3'd7, 2, 0, 1'b0, 7, 32'h44};  // largest count the 3-bit field holds
        tbl[4] = '{2'd0, 3'd4, 0, 2, 1'b0, 4, 32'h44};
        tbl[5] = '{2'd2, 3'd5, 1, 1, 1'b1, 5, 32'h33};
        tbl[6] = '{2'd3, 3'd1, 0, 1, 1'b1, 1, 32'h44};

        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("tie_write", avm_write, 0);
        chk("tie_byteenable", avm_byteenable, 4'hF);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Cycle-exact latency and throughput of a 4-word job
        @(posedge clk); #1;
        out_ready = 1'b1; start = 1'b1; base_addr = 2'd0; word_count = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_c1_read", avm_read, 1);
        chk("lat_c1_addr", avm_address, 0);
        chk("lat_c1_busy", busy, 1);
        chk("lat_c1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_stream_valid", out_valid, 1);
            chk("lat_stream_data", out_data, 32'h11 * (i + 1));
            chk("lat_stream_nodone", done, 0);
        end
        @(negedge clk);
        chk("lat_done", done, 1);
        chk("lat_idle", busy, 0);
        @(negedge clk);
        chk("lat_done_pulse", done, 0);
        @(posedge clk); #1;

        // Table-driven jobs
        for (int k = 0; k < 7; k++) begin
            run_job(tbl[k].base, tbl[k].cnt, tbl[k].rm, tbl[k].wm, tbl[k].spur,
                    tbl[k].exp_reads, tbl[k].exp_last);
        end

        // Reset after the second accepted read of a 4-word job
        mon_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; avm_waitrequest = 1'b0;
        start = 1'b1; base_addr = 2'd0; word_count = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_read", avm_read, 0);
        repeat (3) begin
            @(negedge clk);
            chk("postrst_done", done, 0);
            chk("postrst_valid", out_valid, 0);
            chk("postrst_read", avm_read, 0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_job(2'd1, 3'd3, 0, 0, 1'b0, 3, 32'h44);

        // Random jobs on random RAM contents
        for (int k = 0; k < 25; k++) begin
            for (int a = 0; a < RAM_WORDS; a++) ram[a] = $urandom();
            rb = 2'($urandom_range(0, 3));
            rn = 3'($urandom_range(0, 7));
            rl = (rn != 0) ? ram[(int'(rb) + int'(rn) - 1) % RAM_WORDS] : '0;
            run_job(rb, rn, $urandom_range(0, 1), $urandom_range(0, 1),
                    1'($urandom_range(0, 1)), int'(rn), rl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
